rr_thermo_arbiter: RTL

//  Round-robin arbiter sharing one resource (bus port, shared FSM, cache port) among N requesters.

---
 rtl/rr_thermo_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/rr_thermo_arbiter.sv
// rr_thermo_arbiter: registered round-robin arbiter with thermometer-mask rotating priority (optional forced revoke under ARB_TIMEOUT_EN)
module rr_thermo_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         Req,
  input  logic                 Done,
  output logic [N-1:0]         Grant,
  output logic [$clog2(N)-1:0] GrantIdx,
  output logic                 Busy,
  output logic                 Timeout
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, BUSY} state_t;
  if (N < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rr_thermo_arbiter: N must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   mask, masked, pool, sel_oh;
  logic [IW-1:0]  sel_idx;
  logic           expire, rel, arb;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  assign expire  = (state_q == BUSY) && !Done && Req[idx_q] && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign Timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign Timeout = 1'b0;
`endif
  // rotating priority: eligible set is requests above the last owner, else all requests; winner is the isolated lowest set bit
  always_comb begin
    mask   = ~(((N'(1) << idx_q) << 1) - N'(1));
    masked = Req & mask;
    pool   = |masked ? masked : Req;
    sel_oh = pool & (~pool + N'(1));
  end
  // one-hot winner to binary index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) sel_idx = sel_idx | (sel_oh[i] ? IW'(i) : '0);
  end
  // arbitrate when idle or when the owner lets go (Done, withdrawn request or expired hold)
  always_comb begin
    rel     = (state_q == BUSY) && (Done || !Req[idx_q] || expire);
    arb     = (state_q == IDLE) || rel;
    state_d = arb ? (|Req ? BUSY : IDLE) : state_q;
    grant_d = arb ? sel_oh : grant_q;
    idx_d   = (arb && |Req) ? sel_idx : idx_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = arb ? '0 : cnt_q + CW'(1);
    timeout_d = expire;
`endif
  end
  // ownership FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= IW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign Grant    = grant_q;
  assign GrantIdx = idx_q;
  assign Busy     = (state_q == BUSY);
endmodule
